// File: rtl/alu_exec_seq_pkg.sv
// alu_exec_seq_pkg: shared encodings for the sequential execute unit.
// Holds ALU op codes (including PASS), base and M-extension funct3 codes,
// op-class codes, FSM state encodings and small decode helpers.
package alu_exec_seq_pkg;

  // Op class carried on op_in
  localparam logic [1:0] OPC_ADD = 2'b00;
  localparam logic [1:0] OPC_SUB = 2'b01;
  localparam logic [1:0] OPC_R   = 2'b10;
  localparam logic [1:0] OPC_I   = 2'b11;

  // Base integer funct3 codes
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Decoded ALU code reported on alu_op. All M operations share ALU_MDU;
  // the specific M operation travels separately as md_op_e.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_PASS = 4'd10,
    ALU_MDU  = 4'd11
  } alu_op_e;

  // M-extension funct3 codes
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Base op for a funct3 when bit 30 does not select SUB/SRA
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      F3_ADD_SUB: base_op = ALU_ADD;
      F3_SLL:     base_op = ALU_SLL;
      F3_SLT:     base_op = ALU_SLT;
      F3_SLTU:    base_op = ALU_SLTU;
      F3_XOR:     base_op = ALU_XOR;
      F3_SR:      base_op = ALU_SRL;
      F3_OR:      base_op = ALU_OR;
      default:    base_op = ALU_AND;
    endcase
  endfunction

  function automatic logic md_a_signed(input md_op_e op);
    md_a_signed = (op == MD_MULH) || (op == MD_MULHSU) ||
                  (op == MD_DIV)  || (op == MD_REM);
  endfunction

  function automatic logic md_b_signed(input md_op_e op);
    md_b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/alu_exec_seq_mdu.sv
// mdu_iter: iterative multiply/divide datapath, one bit per cycle.
// Operands are reduced to magnitudes on start; the sign is applied to the
// final iteration's values so the result is ready on the done cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset (aborts any operation)
//   i_start       load operands and begin XLEN iterations
//   i_op          M operation (md_op_e)
//   i_a, i_b      rs1 / rs2 operands
//   o_done        high during the last iteration cycle
//   o_result      final result, valid while o_done is high
module mdu_iter
  import alu_exec_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  md_op_e          i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CW = $clog2(XLEN);

  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_mcand;
  md_op_e          r_op;
  logic            r_neg;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_neg;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rs;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_hi_n;
  logic [XLEN-1:0] w_lo_n;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0] w_q;
  logic [XLEN-1:0] w_r;

  // Operand preparation for start
  always_comb begin
    w_a_neg = md_a_signed(i_op) && i_a[XLEN-1];
    w_b_neg = md_b_signed(i_op) && i_b[XLEN-1];
    w_a_mag = w_a_neg ? -i_a : i_a;
    w_b_mag = w_b_neg ? -i_b : i_b;
    // Remainder sign follows the dividend only
    w_neg   = (i_op == MD_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
  end

  // One iteration: shift-add for multiply (product builds in {hi,lo} from
  // the top), restoring step for divide (remainder in hi, quotient into lo).
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    w_rs   = {r_hi, r_lo[XLEN-1]};
    w_diff = w_rs - {1'b0, r_mcand};
    if (r_op[2]) begin
      if (!w_diff[XLEN]) begin
        w_hi_n = w_diff[XLEN-1:0];
        w_lo_n = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_n = w_rs[XLEN-1:0];
        w_lo_n = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_n = w_sum[XLEN:1];
      w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  always_comb begin
    w_prod     = {w_hi_n, w_lo_n};
    w_prod_fix = r_neg ? -w_prod : w_prod;
    w_q        = r_neg ? -w_lo_n : w_lo_n;
    w_r        = r_neg ? -w_hi_n : w_hi_n;
    case (r_op)
      MD_MUL:                       o_result = w_prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              o_result = w_q;
      default:                      o_result = w_r;
    endcase
    o_done = r_busy && (r_cnt == CW'(XLEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_op    <= MD_MUL;
      r_neg   <= 1'b0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= i_op[2] ? w_a_mag : w_b_mag;
      r_mcand <= i_op[2] ? w_b_mag : w_a_mag;
      r_op    <= i_op;
      r_neg   <= w_neg;
    end else if (r_busy) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: sequential execute unit. Decodes the request, computes base
// ALU ops in one cycle, and runs M operations through mdu_iter.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   op_in, funct3,
//   funct7_5, funct7_0       op class and instruction fields
//   a, b                     rs1 and rs2/imm operands
//   in_valid / in_ready      request handshake
//   out_valid                one-cycle completion pulse
//   result, alu_op           registered result and decoded ALU code
//   busy                     high while an iterative M op runs
module alu_exec_seq
  import alu_exec_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      op_in,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_op,
  output logic            busy
);

  state_e          r_state;
  state_e          w_state_next;
  alu_op_e         r_alu_op;
  logic [XLEN-1:0] r_result;

  alu_op_e         w_alu_op;
  logic            w_is_md;
  md_op_e          w_md_op;
  logic [XLEN-1:0] w_base_res;
  logic [SHW-1:0]  w_shamt;
  logic            w_accept;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_mdu_start;
  logic            w_mdu_done;
  logic [XLEN-1:0] w_mdu_res;

  // Decode
  always_comb begin
    w_alu_op = ALU_PASS;
    w_is_md  = 1'b0;
    w_md_op  = md_op_e'(funct3);
    case (op_in)
      OPC_ADD: w_alu_op = ALU_ADD;
      OPC_SUB: w_alu_op = ALU_SUB;
      OPC_R: begin
        if (!funct7_0) begin
          if (!funct7_5)                w_alu_op = base_op(funct3);
          else if (funct3 == F3_ADD_SUB) w_alu_op = ALU_SUB;
          else if (funct3 == F3_SR)      w_alu_op = ALU_SRA;
          else                           w_alu_op = ALU_PASS;
        end else if (!funct7_5) begin
          w_alu_op = ALU_MDU;
          w_is_md  = 1'b1;
        end
      end
      default: begin
        if ((funct3 == F3_SR) && funct7_5) w_alu_op = ALU_SRA;
        else                               w_alu_op = base_op(funct3);
      end
    endcase
  end

  // Base ALU
  always_comb begin
    w_shamt = b[SHW-1:0];
    case (w_alu_op)
      ALU_ADD:  w_base_res = a + b;
      ALU_SUB:  w_base_res = a - b;
      ALU_AND:  w_base_res = a & b;
      ALU_OR:   w_base_res = a | b;
      ALU_XOR:  w_base_res = a ^ b;
      ALU_SLL:  w_base_res = a << w_shamt;
      ALU_SRL:  w_base_res = a >> w_shamt;
      ALU_SRA:  w_base_res = $unsigned($signed(a) >>> w_shamt);
      ALU_SLT:  w_base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: w_base_res = {{(XLEN-1){1'b0}}, (a < b)};
      default:  w_base_res = b;
    endcase
  end

  // Divide corner cases resolve without iterating
  always_comb begin
    w_div_zero = w_is_md && w_md_op[2] && (b == '0);
    w_div_ovf  = w_is_md && w_md_op[2] && !w_md_op[0] &&
                 (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    w_special  = w_div_zero || w_div_ovf;
    if (w_div_zero) w_special_res = w_md_op[1] ? a : '1;
    else            w_special_res = w_md_op[1] ? '0 : a;
  end

  always_comb begin
    w_accept    = in_valid && (r_state != ST_CALC);
    w_mdu_start = w_accept && w_is_md && !w_special;
  end

  mdu_iter #(
    .XLEN(XLEN)
  ) u_mdu (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_mdu_start),
    .i_op     (w_md_op),
    .i_a      (a),
    .i_b      (b),
    .o_done   (w_mdu_done),
    .o_result (w_mdu_res)
  );

  // FSM next state and outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b1;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        out_valid = (r_state == ST_DONE);
        if (w_accept) w_state_next = w_mdu_start ? ST_CALC : ST_DONE;
        else          w_state_next = ST_IDLE;
      end
      ST_CALC: begin
        in_ready = 1'b0;
        busy     = 1'b1;
        if (w_mdu_done) w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    result = r_result;
    alu_op = r_alu_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_alu_op <= ALU_PASS;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_alu_op <= w_alu_op;
        if (!w_is_md)       r_result <= w_base_res;
        else if (w_special) r_result <= w_special_res;
      end else if ((r_state == ST_CALC) && w_mdu_done) begin
        r_result <= w_mdu_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op_in;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        funct7_0;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic [3:0]  alu_op;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_exec_seq #(
    .XLEN(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .op_in     (op_in),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .funct7_0  (funct7_0),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .result    (result),
    .alu_op    (alu_op),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                       input logic f70, input logic [31:0] ia, input logic [31:0] ib);
    op_in = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70; a = ia; b = ib;
    in_valid = 1'b1;
  endtask

  // Returns at the negedge of the cycle after accept
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                       input logic f70, input logic [31:0] ia, input logic [31:0] ib);
    @(negedge clk);
    drive(op, f3, f75, f70, ia, ib);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // cyc = cycles after accept at which out_valid was seen
  task automatic wait_out(input bit pulse, output int cyc, output int bcnt);
    cyc = 1;
    bcnt = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) bcnt++;
      if (pulse && cyc == 10) drive(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
      if (pulse && cyc == 11) in_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int bcnt;
    int ov;

    rst = 1'b1; in_valid = 1'b0;
    op_in = '0; funct3 = '0; funct7_5 = 1'b0; funct7_0 = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_result",    result,         32'd0);
    chk("rst_alu_op",    32'(alu_op),    32'd10);
    rst = 1'b0;

    // R-format SUB
    issue(2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7);
    chk("sub_valid",  32'(out_valid), 32'd1);
    chk("sub_result", result,         32'hFFFFFFFE);
    chk("sub_alu_op", 32'(alu_op),    32'd1);

    // Back-to-back SRAI then SRLI
    @(negedge clk);
    drive(2'b11, 3'b101, 1'b1, 1'b0, 32'h80000000, 32'd4);
    @(negedge clk);
    drive(2'b11, 3'b101, 1'b0, 1'b0, 32'h80000000, 32'd4);
    chk("srai_valid",  32'(out_valid), 32'd1);
    chk("srai_result", result,         32'hF8000000);
    @(negedge clk);
    in_valid = 1'b0;
    chk("srli_valid",  32'(out_valid), 32'd1);
    chk("srli_result", result,         32'h08000000);
    @(negedge clk);
    chk("idle_after_b2b", 32'(out_valid), 32'd0);

    // Base op patterns
    issue(2'b00, 3'b000, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1);
    chk("add_wrap", result, 32'd0);
    issue(2'b01, 3'b000, 1'b0, 1'b0, 32'd0, 32'd1);
    chk("sub_wrap", result, 32'hFFFFFFFF);
    issue(2'b10, 3'b010, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1);
    chk("slt", result, 32'd1);
    issue(2'b10, 3'b011, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1);
    chk("sltu", result, 32'd0);
    issue(2'b10, 3'b100, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00);
    chk("xor", result, 32'h0FF00FF0);
    issue(2'b11, 3'b000, 1'b1, 1'b0, 32'd3, 32'd4);
    chk("addi_f75_ignored", result, 32'd7);
    issue(2'b11, 3'b001, 1'b0, 1'b0, 32'd1, 32'd31);
    chk("slli_31", result, 32'h80000000);
    issue(2'b11, 3'b001, 1'b0, 1'b0, 32'd1, 32'h21);
    chk("slli_shamt_mask", result, 32'd2);
    issue(2'b10, 3'b000, 1'b1, 1'b1, 32'd3, 32'h12345678);
    chk("pass_result", result,      32'h12345678);
    chk("pass_alu_op", 32'(alu_op), 32'd10);

    // MULHSU with an ignored mid-CALC request
    issue(2'b10, 3'b010, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2);
    chk("calc_in_ready", 32'(in_ready), 32'd0);
    wait_out(1'b1, cyc, bcnt);
    chk("mulhsu_latency", 32'(cyc),   32'd33);
    chk("mulhsu_busy",    32'(bcnt),  32'd32);
    chk("mulhsu_result",  result,     32'hFFFFFFFF);
    chk("mulhsu_alu_op",  32'(alu_op), 32'd11);
    @(negedge clk);
    chk("mulhsu_no_extra", 32'(out_valid), 32'd0);

    issue(2'b10, 3'b000, 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5);
    wait_out(1'b0, cyc, bcnt);
    chk("mul_latency", 32'(cyc), 32'd33);
    chk("mul_result",  result,   32'hFFFFFFF1);

    issue(2'b10, 3'b011, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_out(1'b0, cyc, bcnt);
    chk("mulhu_result", result, 32'hFFFFFFFE);

    issue(2'b10, 3'b001, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_out(1'b0, cyc, bcnt);
    chk("mulh_result", result, 32'd0);

    // Divide special cases finish in one cycle
    issue(2'b10, 3'b100, 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_valid",  32'(out_valid), 32'd1);
    chk("div_ovf_result", result,         32'h80000000);
    issue(2'b10, 3'b110, 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    chk("rem_ovf_result", result, 32'd0);
    issue(2'b10, 3'b111, 1'b0, 1'b1, 32'd9, 32'd0);
    chk("remu_zero_valid",  32'(out_valid), 32'd1);
    chk("remu_zero_result", result,         32'd9);
    issue(2'b10, 3'b100, 1'b0, 1'b1, 32'd5, 32'd0);
    chk("div_zero_result", result, 32'hFFFFFFFF);

    issue(2'b10, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7);
    wait_out(1'b0, cyc, bcnt);
    chk("divu_latency", 32'(cyc), 32'd33);
    chk("divu_result",  result,   32'd14);

    issue(2'b10, 3'b100, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    wait_out(1'b0, cyc, bcnt);
    chk("div_neg_result", result, 32'hFFFFFFFD);

    // Abort DIV with reset at cycle 10
    issue(2'b10, 3'b100, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy",      32'(busy),      32'd0);
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    chk("abort_result",    result,         32'd0);
    ov = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1) ov++;
    end
    chk("abort_no_valid", 32'(ov), 32'd0);

    issue(2'b10, 3'b110, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    wait_out(1'b0, cyc, bcnt);
    chk("rem_neg_latency", 32'(cyc), 32'd33);
    chk("rem_neg_result",  result,   32'hFFFFFFFF);

    // Reset wins over a simultaneous accept
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rstprio_out_valid", 32'(out_valid), 32'd0);
    chk("rstprio_result",    result,         32'd0);
    chk("rstprio_alu_op",    32'(alu_op),    32'd10);
    @(negedge clk);
    chk("rstprio_dropped", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
